// File: rtl/mastermind_pkg.sv
// Shared types and defaults for the Mastermind round sequencer.
// Optional build macro MM_FREE_PLAY_EN is consumed by mm_credit_bank.
package mastermind_pkg;

    localparam int DEF_COST       = 4;
    localparam int DEF_MAX_ROUNDS = 8;
    localparam int DEF_MAX_GAMES  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MASTER,
        PLAY,
        GRADE_WAIT,
        OVER
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE     = 2'b00,
        COIN_CIRCLE   = 2'b01,
        COIN_TRIANGLE = 2'b10,
        COIN_PENTAGON = 2'b11
    } coin_t;

    function automatic logic [2:0] coin_zorkmids(input coin_t v);
        case (v)
            COIN_CIRCLE:   return 3'd1;
            COIN_TRIANGLE: return 3'd3;
            COIN_PENTAGON: return 3'd5;
            default:       return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mm_credit_bank.sv
// Coin credit accumulator and banked game counter.
// MM_FREE_PLAY_EN: coins ignored, count pinned at MAX_GAMES, starts always allowed.
module mm_credit_bank
    import mastermind_pkg::*;
#(
    parameter int COST      = DEF_COST,
    parameter int MAX_GAMES = DEF_MAX_GAMES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       coin,
    input  logic [1:0] coin_value,
    input  logic       consume,
    output logic [3:0] num_games,
    output logic       load_num_games,
    output logic       game_ready
);

`ifdef MM_FREE_PLAY_EN
    logic unused_inputs;

    assign unused_inputs  = ^{clock, reset_n, coin, coin_value, consume};
    assign num_games      = 4'(MAX_GAMES);
    assign load_num_games = 1'b0;
    assign game_ready     = 1'b1;
`else
    logic [3:0] credit_q;
    logic [3:0] credit_n;
    logic [3:0] games_coin;
    logic [3:0] games_n;
    logic [4:0] sum;
    logic [4:0] diff;

    // The coin is applied first so a same-cycle start sees the updated count.
    always_comb begin
        credit_n   = credit_q;
        games_coin = num_games;
        sum        = {1'b0, credit_q} + {2'b00, coin_zorkmids(coin_t'(coin_value))};
        diff       = sum - 5'(COST);
        if (coin) begin
            if (sum >= 5'(COST) && num_games < 4'(MAX_GAMES)) begin
                credit_n   = (diff > 5'd15) ? 4'd15 : diff[3:0];
                games_coin = num_games + 4'd1;
            end else begin
                credit_n = (sum > 5'd15) ? 4'd15 : sum[3:0];
            end
        end
        game_ready = (games_coin != 4'd0);
        games_n    = (consume && game_ready) ? games_coin - 4'd1 : games_coin;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credit_q       <= 4'd0;
            num_games      <= 4'd0;
            load_num_games <= 1'b0;
        end else begin
            credit_q       <= credit_n;
            num_games      <= games_n;
            load_num_games <= (games_n != num_games);
        end
    end
`endif

endmodule

// File: rtl/mastermind_round_sequencer.sv
// Game-flow FSM: master pattern load, guess/grade rounds, win/lose end.
// Credit accounting lives in mm_credit_bank (MM_FREE_PLAY_EN applies there).
module mastermind_round_sequencer
    import mastermind_pkg::*;
#(
    parameter int COST       = DEF_COST,
    parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
    parameter int MAX_GAMES  = DEF_MAX_GAMES
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       coinInserted,
    input  logic [1:0] coinValue,
    input  logic       startGame,
    input  logic       loadShapeNow,
    input  logic       gradeReq,
    input  logic [1:0] shapeLocation,
    input  logic       gradeDone,
    input  logic       gameWon,
    output logic [3:0] numGames,
    output logic       loadNumGames,
    output logic [3:0] roundNumber,
    output logic [3:0] masterEn,
    output logic       loadGuess,
    output logic       loadZnarlyZood,
    output logic       clearGame,
    output logic       gradeStart,
    output logic       gameActive,
    output logic       gameOver
);

    state_t     state_q, state_n;
    logic [3:0] round_n;
    logic [3:0] mask_q, mask_n;
    logic       game_ready;
    logic       consume;

    mm_credit_bank #(
        .COST      (COST),
        .MAX_GAMES (MAX_GAMES)
    ) u_bank (
        .clock          (clock),
        .reset_n        (reset_n),
        .coin           (coinInserted),
        .coin_value     (coinValue),
        .consume        (consume),
        .num_games      (numGames),
        .load_num_games (loadNumGames),
        .game_ready     (game_ready)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            roundNumber <= 4'd0;
            mask_q      <= 4'd0;
        end else begin
            state_q     <= state_n;
            roundNumber <= round_n;
            mask_q      <= mask_n;
        end
    end

    // Strobes are Mealy and qualified by reset_n so they drop the instant reset asserts.
    always_comb begin
        state_n        = state_q;
        round_n        = roundNumber;
        mask_n         = mask_q;
        masterEn       = 4'd0;
        loadGuess      = 1'b0;
        loadZnarlyZood = 1'b0;
        clearGame      = 1'b0;
        gradeStart     = 1'b0;
        consume        = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE, OVER: begin
                    if (startGame && game_ready) begin
                        consume   = 1'b1;
                        clearGame = 1'b1;
                        mask_n    = 4'd0;
                        round_n   = 4'd0;
                        state_n   = LOAD_MASTER;
                    end
                end
                LOAD_MASTER: begin
                    if (loadShapeNow) begin
                        masterEn = 4'b0001 << shapeLocation;
                        mask_n   = mask_q | masterEn;
                    end
                    if (startGame && (&mask_q)) begin
                        round_n = 4'd1;
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (gradeReq) begin
                        loadGuess  = 1'b1;
                        gradeStart = 1'b1;
                        state_n    = GRADE_WAIT;
                    end
                end
                GRADE_WAIT: begin
                    if (gradeDone) begin
                        loadZnarlyZood = 1'b1;
                        if (gameWon || roundNumber == 4'(MAX_ROUNDS)) begin
                            state_n = OVER;
                        end else begin
                            round_n = roundNumber + 4'd1;
                            state_n = PLAY;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign gameActive = (state_q == LOAD_MASTER) || (state_q == PLAY) || (state_q == GRADE_WAIT);
    assign gameOver   = (state_q == OVER);

endmodule

// File: tb/tb_mastermind_round_sequencer.sv
// Directed bench for the Mastermind round sequencer (default build).
module tb_mastermind_round_sequencer;
    import mastermind_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       coinInserted = 1'b0;
    logic [1:0] coinValue = 2'b00;
    logic       startGame = 1'b0;
    logic       loadShapeNow = 1'b0;
    logic       gradeReq = 1'b0;
    logic [1:0] shapeLocation = 2'b00;
    logic       gradeDone = 1'b0;
    logic       gameWon = 1'b0;
    logic [3:0] numGames;
    logic       loadNumGames;
    logic [3:0] roundNumber;
    logic [3:0] masterEn;
    logic       loadGuess, loadZnarlyZood, clearGame, gradeStart, gameActive, gameOver;

    int tests = 0;
    int fails = 0;

    mastermind_round_sequencer dut (
        .clock(clock), .reset_n(reset_n), .coinInserted(coinInserted), .coinValue(coinValue),
        .startGame(startGame), .loadShapeNow(loadShapeNow), .gradeReq(gradeReq),
        .shapeLocation(shapeLocation), .gradeDone(gradeDone), .gameWon(gameWon),
        .numGames(numGames), .loadNumGames(loadNumGames), .roundNumber(roundNumber),
        .masterEn(masterEn), .loadGuess(loadGuess), .loadZnarlyZood(loadZnarlyZood),
        .clearGame(clearGame), .gradeStart(gradeStart), .gameActive(gameActive),
        .gameOver(gameOver)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic coin(input logic [1:0] v);
        coinInserted = 1'b1; coinValue = v;
        tick();
        coinInserted = 1'b0; coinValue = 2'b00;
    endtask

    task automatic press_start();
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
    endtask

    task automatic load_slot(input logic [1:0] s);
        shapeLocation = s; loadShapeNow = 1'b1;
        tick();
        loadShapeNow = 1'b0;
    endtask

    task automatic play_round(input logic won);
        gradeReq = 1'b1;
        tick();
        gradeReq = 1'b0;
        gradeDone = 1'b1; gameWon = won;
        tick();
        gradeDone = 1'b0; gameWon = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        tests++;
        if ({numGames, loadNumGames, roundNumber, masterEn, loadGuess, loadZnarlyZood,
             clearGame, gradeStart, gameActive, gameOver} !== 20'd0) begin
            fails++; $display("FAIL reset_outputs got %h want 0", {numGames, loadNumGames, roundNumber, masterEn});
        end
        tests++;
        if (dut.u_bank.credit_q !== 4'd0) begin fails++; $display("FAIL reset_credit got %0d want 0", dut.u_bank.credit_q); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_coin_pentagon();
        coin(2'b11);
        tests++; if (numGames !== 4'd1) begin fails++; $display("FAIL pent_num_games got %0d want 1", numGames); end
        tests++; if (dut.u_bank.credit_q !== 4'd1) begin fails++; $display("FAIL pent_credit got %0d want 1", dut.u_bank.credit_q); end
        tests++; if (loadNumGames !== 1'b1) begin fails++; $display("FAIL pent_load got %b want 1", loadNumGames); end
        tick();
        tests++; if (loadNumGames !== 1'b0) begin fails++; $display("FAIL pent_load_once got %b want 0", loadNumGames); end
    endtask

    task automatic test_circle_triangle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            coin(2'b01);
            tests++; if (numGames !== 4'd0) begin fails++; $display("FAIL circle%0d_num_games got %0d want 0", i, numGames); end
            tests++; if (dut.u_bank.credit_q !== 4'(i + 1)) begin fails++; $display("FAIL circle%0d_credit got %0d want %0d", i, dut.u_bank.credit_q, i + 1); end
        end
        coin(2'b10);
        tests++; if (numGames !== 4'd1) begin fails++; $display("FAIL tri_num_games got %0d want 1", numGames); end
        tests++; if (dut.u_bank.credit_q !== 4'd2) begin fails++; $display("FAIL tri_credit got %0d want 2", dut.u_bank.credit_q); end
        tests++; if (loadNumGames !== 1'b1) begin fails++; $display("FAIL tri_load got %b want 1", loadNumGames); end
    endtask

    task automatic test_load_master();
        logic [3:0] exp;
        startGame = 1'b1;
        #1;
        tests++; if (clearGame !== 1'b1) begin fails++; $display("FAIL start_clear got %b want 1", clearGame); end
        tick();
        startGame = 1'b0;
        tests++; if (gameActive !== 1'b1) begin fails++; $display("FAIL start_active got %b want 1", gameActive); end
        tests++; if (numGames !== 4'd0) begin fails++; $display("FAIL start_num_games got %0d want 0", numGames); end
        tests++; if (loadNumGames !== 1'b1) begin fails++; $display("FAIL start_load got %b want 1", loadNumGames); end
        for (int s = 0; s < 3; s++) begin
            shapeLocation = 2'(s); loadShapeNow = 1'b1;
            exp = 4'b0001 << s;
            #1;
            tests++; if (masterEn !== exp) begin fails++; $display("FAIL master_en%0d got %b want %b", s, masterEn, exp); end
            tick();
            loadShapeNow = 1'b0;
        end
        press_start();
        tests++; if (dut.state_q !== LOAD_MASTER) begin fails++; $display("FAIL partial_start state got %0d want %0d", dut.state_q, LOAD_MASTER); end
        tests++; if (roundNumber !== 4'd0) begin fails++; $display("FAIL partial_start round got %0d want 0", roundNumber); end
        load_slot(2'd3);
        press_start();
        tests++; if (dut.state_q !== PLAY) begin fails++; $display("FAIL full_start state got %0d want %0d", dut.state_q, PLAY); end
        tests++; if (roundNumber !== 4'd1) begin fails++; $display("FAIL full_start round got %0d want 1", roundNumber); end
    endtask

    task automatic test_eight_rounds();
        for (int r = 1; r <= 8; r++) begin
            tests++; if (roundNumber !== 4'(r)) begin fails++; $display("FAIL round_number got %0d want %0d", roundNumber, r); end
            gradeReq = 1'b1;
            #1;
            tests++; if ({loadGuess, gradeStart} !== 2'b11) begin fails++; $display("FAIL grade_strobes r%0d got %b want 11", r, {loadGuess, gradeStart}); end
            tick();
            gradeReq = 1'b0;
            tests++; if (dut.state_q !== GRADE_WAIT) begin fails++; $display("FAIL grade_wait r%0d got %0d want %0d", r, dut.state_q, GRADE_WAIT); end
            if (r == 1) begin
                gradeReq = 1'b1;
                #1;
                tests++; if (loadGuess !== 1'b0) begin fails++; $display("FAIL grade_ignored got %b want 0", loadGuess); end
                tick();
                gradeReq = 1'b0;
            end
            gradeDone = 1'b1; gameWon = 1'b0;
            #1;
            tests++; if (loadZnarlyZood !== 1'b1) begin fails++; $display("FAIL zood r%0d got %b want 1", r, loadZnarlyZood); end
            tick();
            gradeDone = 1'b0;
        end
        tests++; if (gameOver !== 1'b1) begin fails++; $display("FAIL lose_over got %b want 1", gameOver); end
        tests++; if (gameActive !== 1'b0) begin fails++; $display("FAIL lose_active got %b want 0", gameActive); end
        tests++; if (roundNumber !== 4'd8) begin fails++; $display("FAIL lose_round got %0d want 8", roundNumber); end
    endtask

    task automatic test_win_round3();
        coin(2'b11);
        tests++; if (numGames !== 4'd1) begin fails++; $display("FAIL over_coin num_games got %0d want 1", numGames); end
        press_start();
        for (int s = 0; s < 4; s++) load_slot(2'(s));
        press_start();
        tests++; if (roundNumber !== 4'd1) begin fails++; $display("FAIL win_game_start round got %0d want 1", roundNumber); end
        play_round(1'b0);
        play_round(1'b0);
        tests++; if (roundNumber !== 4'd3) begin fails++; $display("FAIL win_round3 got %0d want 3", roundNumber); end
        play_round(1'b1);
        tests++; if (gameOver !== 1'b1) begin fails++; $display("FAIL win_over got %b want 1", gameOver); end
        tests++; if (roundNumber !== 4'd3) begin fails++; $display("FAIL win_round_hold got %0d want 3", roundNumber); end
        startGame = 1'b1;
        #1;
        tests++; if (clearGame !== 1'b0) begin fails++; $display("FAIL no_credit_clear got %b want 0", clearGame); end
        tick();
        startGame = 1'b0;
        tests++; if (gameOver !== 1'b1) begin fails++; $display("FAIL no_credit_stay_over got %b want 1", gameOver); end
    endtask

    task automatic test_coin_and_start();
        tests++; if (dut.u_bank.credit_q !== 4'd3) begin fails++; $display("FAIL pre_credit got %0d want 3", dut.u_bank.credit_q); end
        coinInserted = 1'b1; coinValue = 2'b01; startGame = 1'b1;
        #1;
        tests++; if (clearGame !== 1'b1) begin fails++; $display("FAIL coin_start_clear got %b want 1", clearGame); end
        tick();
        coinInserted = 1'b0; coinValue = 2'b00; startGame = 1'b0;
        tests++; if (gameActive !== 1'b1) begin fails++; $display("FAIL coin_start_active got %b want 1", gameActive); end
        tests++; if (numGames !== 4'd0) begin fails++; $display("FAIL coin_start_games got %0d want 0", numGames); end
        tests++; if (loadNumGames !== 1'b0) begin fails++; $display("FAIL coin_start_load got %b want 0", loadNumGames); end
        tests++; if (dut.u_bank.credit_q !== 4'd0) begin fails++; $display("FAIL coin_start_credit got %0d want 0", dut.u_bank.credit_q); end
    endtask

    task automatic test_reset_midgame();
        for (int s = 0; s < 4; s++) load_slot(2'(s));
        press_start();
        gradeReq = 1'b1;
        tick();
        gradeReq = 1'b0;
        tests++; if (dut.state_q !== GRADE_WAIT) begin fails++; $display("FAIL mid_grade_wait got %0d want %0d", dut.state_q, GRADE_WAIT); end
        gradeDone = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({numGames, loadNumGames, roundNumber, masterEn, loadGuess, loadZnarlyZood,
             clearGame, gradeStart, gameActive, gameOver} !== 20'd0) begin
            fails++; $display("FAIL mid_reset_outputs got %h want 0", {roundNumber, loadZnarlyZood, gameActive});
        end
        gradeDone = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL mid_reset_idle got %0d want %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            coin(2'b11);
            if (i == 7) begin
                tests++; if (numGames !== 4'd7) begin fails++; $display("FAIL sat_reach got %0d want 7", numGames); end
            end
        end
        tests++; if (numGames !== 4'd7) begin fails++; $display("FAIL sat_hold got %0d want 7", numGames); end
        tests++; if (dut.u_bank.credit_q !== 4'd15) begin fails++; $display("FAIL sat_credit got %0d want 15", dut.u_bank.credit_q); end
        tests++; if (loadNumGames !== 1'b0) begin fails++; $display("FAIL sat_load got %b want 0", loadNumGames); end
    endtask

    initial begin
        test_reset();
        test_coin_pentagon();
        test_circle_triangle();
        test_load_master();
        test_eight_rounds();
        test_win_round3();
        test_coin_and_start();
        test_reset_midgame();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
